// File: rtl/mult_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_unit_if : operand/control/result bundle between the execute stage and
//                the HI/LO multiplier.            Rev 1.0
// ---------------------------------------------------------------------------
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             multLoad;
  logic             isSigned;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] wData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output multLoad, isSigned, opA, opB, hiWrite, loWrite, wData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  multLoad, isSigned, opA, opB, hiWrite, loWrite, wData,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mult_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_unit : radix-2 shift-add HI/LO multiplier, one multiplier bit per clock
//             with a final sign fix-up.           Rev 1.0
// ---------------------------------------------------------------------------
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mult_unit_if.slave bus
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_RUN  = 2'd1;
  localparam logic [1:0]       S_FIX  = 2'd2;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic               w_idle;
  logic               w_run;
  logic               w_fix;
  logic               w_load;

  logic [WIDTH-1:0]   r_magA;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_negRes;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.multLoad) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle = 1'b0;
    w_run  = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_idle = 1'b1;
      S_RUN:   w_run  = 1'b1;
      S_FIX:   w_fix  = 1'b1;
      default: w_idle = 1'b1;
    endcase
  end

  assign w_load = w_idle & bus.multLoad;

  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
  assign w_magA = (bus.isSigned && bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
  assign w_magB = (bus.isSigned && bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (r_mplr[0] ? r_magA : {WIDTH{1'b0}})};
  assign w_result = r_negRes ? -r_acc : r_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_magA   <= '0;
      r_mplr   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_magA   <= w_magA;
        r_mplr   <= w_magB;
        r_negRes <= bus.isSigned & (bus.opA[WIDTH-1] ^ bus.opB[WIDTH-1]);
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_run) begin
        // Carry-out of the add becomes the new MSB as the pair shifts right.
        r_acc  <= {w_sum, r_acc[WIDTH-1:1]};
        r_mplr <= r_mplr >> 1;
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_result[2*WIDTH-1:WIDTH];
      r_lo <= w_result[WIDTH-1:0];
    end else if (w_idle) begin
      if (bus.hiWrite) r_hi <= bus.wData;
      if (bus.loWrite) r_lo <= bus.wData;
    end
  end

  assign bus.busy = ~w_idle;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mult_unit : directed and randomized checks of mult_unit against a
//                plain-arithmetic product model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_mult_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  mult_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    bus.multLoad = 1'b1;
    bus.isSigned = s;
    bus.opA      = a;
    bus.opB      = b;
    step();
    bus.multLoad = 1'b0;
    bus.opA      = $urandom;
    bus.opB      = $urandom;
    bus.isSigned = $urandom_range(0, 1);
  endtask

  // cyc counts edges after the load edge; bcnt counts sample points with busy high.
  task automatic wait_done(input int start, output int cyc, output int bcnt);
    cyc  = start;
    bcnt = 0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) bcnt++;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.multLoad = 1'b0;
    bus.isSigned = 1'b0;
    bus.opA      = '0;
    bus.opB      = '0;
    bus.hiWrite  = 1'b0;
    bus.loWrite  = 1'b0;
    bus.wData    = '0;
    step();
    step();
    rst = 1'b0;
    step();
    n_checks += 4;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    if (bus.hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_mthi_mtlo();
    int cyc, bcnt;
    bus.hiWrite = 1'b1; bus.wData = 32'hA5A5A5A5;
    step();
    bus.hiWrite = 1'b0;
    n_checks++;
    if (bus.hi !== 32'hA5A5A5A5) begin n_errors++; $display("FAIL mthi: got %h want a5a5a5a5", bus.hi); end
    bus.loWrite = 1'b1; bus.wData = 32'h12345678;
    step();
    bus.loWrite = 1'b0;
    n_checks++;
    if (bus.lo !== 32'h12345678) begin n_errors++; $display("FAIL mtlo: got %h want 12345678", bus.lo); end
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.wData = 32'h0BADF00D;
    step();
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo} !== {2{32'h0BADF00D}}) begin
      n_errors++; $display("FAIL mthi_mtlo_both: got %h_%h want 0badf00d_0badf00d", bus.hi, bus.lo);
    end
    start_op(1'b0, 32'd2, 32'd3);
    step(); step();
    bus.loWrite = 1'b1; bus.hiWrite = 1'b1; bus.wData = 32'hDEADBEEF;
    step();
    bus.loWrite = 1'b0; bus.hiWrite = 1'b0;
    n_checks++;
    if ({bus.hi, bus.lo} !== {2{32'h0BADF00D}}) begin
      n_errors++; $display("FAIL write_while_busy: got %h_%h want 0badf00d_0badf00d", bus.hi, bus.lo);
    end
    wait_done(4, cyc, bcnt);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'd6) begin
      n_errors++; $display("FAIL mtlo_then_product: got %h_%h want 0_6", bus.hi, bus.lo);
    end
    step();
  endtask

  task automatic test_reset_midrun();
    int cyc, bcnt, pulses;
    bus.hiWrite = 1'b1; bus.loWrite = 1'b1; bus.wData = 32'h11111111;
    step();
    bus.hiWrite = 1'b0; bus.loWrite = 1'b0;
    start_op(1'b0, 32'd7, 32'd9);
    repeat (9) step();
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL midrun_reset_busy: got %b want 0", bus.busy); end
    if (bus.hi !== 32'h0) begin n_errors++; $display("FAIL midrun_reset_hi: got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin n_errors++; $display("FAIL midrun_reset_lo: got %h want 0", bus.lo); end
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) pulses++;
      step();
    end
    n_checks++;
    if (pulses !== 0) begin n_errors++; $display("FAIL midrun_no_done: got %0d pulses want 0", pulses); end
    start_op(1'b0, 32'd7, 32'd9);
    wait_done(0, cyc, bcnt);
    n_checks++;
    if ({bus.hi, bus.lo} !== 64'h3F) begin
      n_errors++; $display("FAIL after_reset_7x9: got %h_%h want 0_3f", bus.hi, bus.lo);
    end
    step();
  endtask

  task automatic test_signed();
    int cyc, bcnt;
    start_op(1'b1, 32'hFFFFFFFD, 32'd5);
    wait_done(0, cyc, bcnt);
    n_checks += 5;
    if (bus.hi !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL signed_hi: got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFFFFF1) begin n_errors++; $display("FAIL signed_lo: got %h want fffffff1", bus.lo); end
    if (cyc !== LAT) begin n_errors++; $display("FAIL signed_latency: got %0d want %0d", cyc, LAT); end
    if (bcnt !== LAT) begin n_errors++; $display("FAIL signed_busy_cycles: got %0d want %0d", bcnt, LAT); end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL signed_busy_at_done: got %b want 0", bus.busy); end
    step();
    n_checks++;
    if (bus.done !== 1'b0) begin n_errors++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
  endtask

  task automatic test_corners();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    bit          ts [4];
    logic [63:0] exp_p [4];
    int          cyc, bcnt;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'hFFFFFFFF; ts[0] = 1'b0; exp_p[0] = 64'hFFFFFFFE_00000001;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF; ts[1] = 1'b1; exp_p[1] = 64'h00000000_00000001;
    ta[2] = 32'h80000000; tb[2] = 32'h80000000; ts[2] = 1'b1; exp_p[2] = 64'h40000000_00000000;
    ta[3] = 32'h80000000; tb[3] = 32'h00000001; ts[3] = 1'b1; exp_p[3] = 64'hFFFFFFFF_80000000;
    for (int i = 0; i < 4; i++) begin
      start_op(ts[i], ta[i], tb[i]);
      wait_done(0, cyc, bcnt);
      n_checks++;
      if ({bus.hi, bus.lo} !== exp_p[i]) begin
        n_errors++;
        $display("FAIL corner_%0d: got %h_%h want %h", i, bus.hi, bus.lo, exp_p[i]);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    start_op(1'b0, 32'd3, 32'd4);
    repeat (5) step();
    bus.multLoad = 1'b1; bus.opA = 32'd100; bus.opB = 32'd200;
    step();
    bus.multLoad = 1'b0;
    wait_done(6, cyc, bcnt);
    n_checks += 2;
    if ({bus.hi, bus.lo} !== 64'd12) begin
      n_errors++; $display("FAIL ignored_start: got %h_%h want 0_c", bus.hi, bus.lo);
    end
    if (cyc !== LAT) begin n_errors++; $display("FAIL ignored_start_latency: got %0d want %0d", cyc, LAT); end
    start_op(1'b0, 32'd6, 32'd7);
    n_checks += 2;
    if (bus.done !== 1'b0) begin n_errors++; $display("FAIL b2b_done_drop: got %b want 0", bus.done); end
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
    wait_done(0, cyc, bcnt);
    n_checks += 2;
    if ({bus.hi, bus.lo} !== 64'd42) begin
      n_errors++; $display("FAIL b2b_result: got %h_%h want 0_2a", bus.hi, bus.lo);
    end
    if (cyc !== LAT) begin n_errors++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit          s;
    logic [63:0] exp_p;
    int          cyc, bcnt;
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 4) == 0) a = {a[0], 31'd0};
      if ($urandom_range(0, 4) == 0) b = {32{b[0]}};
      s = $urandom_range(0, 1);
      exp_p = model(s, a, b);
      start_op(s, a, b);
      wait_done(0, cyc, bcnt);
      n_checks++;
      if ({bus.hi, bus.lo} !== exp_p || cyc !== LAT) begin
        n_errors++;
        $display("FAIL random_%0d: s=%b a=%h b=%h got %h_%h lat %0d want %h lat %0d",
                 i, s, a, b, bus.hi, bus.lo, cyc, exp_p, LAT);
      end
      if ($urandom_range(0, 1) == 1) step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_reset_midrun();
    test_signed();
    test_corners();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative HI/LO multiplier. Consumes the decoder's `multLoad` strobe plus the two register-file read operands, and produces the 64-bit product in HI/LO registers.
- Sits beside the ALU in the execute path. `busy` feeds the hazard/stall logic. `hi` and `lo` feed the register write-back mux for mfhi/mflo.
- Radix-2 shift-add: one multiplier bit per clock, sign fix-up at the end.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- multLoad  input  1  start strobe from the decoder; sampled on the rising edge.
- isSigned  input  1  1 = mult (two's complement), 0 = multu; sampled with multLoad.
- opA  input  WIDTH  multiplicand (rs); sampled with multLoad.
- opB  input  WIDTH  multiplier (rt); sampled with multLoad.
- hiWrite  input  1  mthi strobe.
- loWrite  input  1  mtlo strobe.
- wData  input  WIDTH  data for mthi/mtlo.
- busy  output  1  multiplication in progress; pipeline must stall mfhi/mflo/mult.
- done  output  1  one-cycle pulse when hi/lo take a new product.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal datapath registers cleared. A reset mid-run discards the operation and no done is produced.
- States:
  - IDLE: waiting for multLoad.
  - RUN: WIDTH iterations.
  - FIX: sign correction and write-back.
- IDLE + multLoad=1 at edge E0:
  - Capture magA and magB. When isSigned=1, each is the absolute value of its operand; when isSigned=0, the raw operands.
  - negRes = isSigned & (opA[MSB] ^ opB[MSB]).
  - acc(2*WIDTH)=0, count=0, go to RUN. busy=1 from E0.
  - 0x80000000 magnitude is 0x80000000 (unsigned interpretation, no overflow).
- RUN, each edge E1..E(WIDTH):
  - If the multiplier LSB is 1, add magA to the upper half of acc (WIDTH+1-bit add including carry).
  - Then shift {carry, acc} right by 1, with the multiplier shifting in lockstep; count++.
  - After count reaches WIDTH-1 and that iteration completes, go to FIX.
- FIX, edge E(WIDTH+1):
  - {hi,lo} = negRes ? -acc : acc (64-bit two's complement).
  - done=1 for exactly the following cycle; busy=0; state=IDLE.
- Latency: multLoad sampled at E0; result visible and done high after E(WIDTH+1), i.e. WIDTH+1 cycles; busy high for exactly WIDTH+1 cycles.
- Back-to-back: a multLoad in the cycle where done=1 is accepted (state is IDLE). done still deasserts at the next edge while busy reasserts.
- multLoad while busy is ignored. The running operation and operands are unaffected. The stall logic must prevent this case; a bench checker flags it.
- hiWrite/loWrite:
  - Ignored while busy.
  - In IDLE, hi/lo (as selected) take wData at the edge; both strobes together write both registers.
  - If multLoad coincides in IDLE, the write still occurs at E0 and is overwritten at E(WIDTH+1).
- hi/lo hold their previous values throughout RUN; no partial products are visible.
- Operand ports are don't-care except at the multLoad edge.

Test Plan:
- Reset mid-run: multLoad with opA=7, opB=9, assert rst at cycle 10 -> hi=lo=0, busy=0 immediately, no done pulse; next multLoad 7*9 -> lo=0x3F, hi=0.
- Signed: isSigned=1, opA=0xFFFFFFFD (-3), opB=5 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done high one cycle, busy high exactly 33 cycles.
- Unsigned max: isSigned=0, opA=opB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with isSigned=1 -> hi=0, lo=1.
- Signed corner: opA=opB=0x80000000, isSigned=1 -> hi=0x40000000, lo=0. opA=0x80000000, opB=1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Back-to-back plus ignored start: issue 3*4, pulse multLoad again mid-run with other operands (ignored) -> lo=12. Issue 6*7 in the done cycle -> busy stays low one cycle only at done, second result lo=42 after 33 more cycles.
- mthi/mtlo: IDLE hiWrite wData=0xA5A5A5A5 -> hi updates next edge. loWrite during busy -> lo unchanged until product write-back.
